// File: rtl/control_unit_types_pkg.sv
// Shared types for the multicycle control path: request-unit states and the word width.
package control_unit_types_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      DATA   = 2'd2,
      HALTED = 2'd3
   } ru_state_t;

   // States in which the unit is blocked on a memory hit and the watchdog runs.
   function automatic logic is_wait_state(input ru_state_t s);
      return (s == FETCH) || (s == DATA);
   endfunction

endpackage

// File: rtl/request_unit_if.sv
// Memory/decoder handshake bundle of the request unit.
// The ru side drives enables and status, mem returns hits and data, cu decodes instr_q.
interface request_unit_if #(
   parameter int CNT_W = 32
);
   import control_unit_types_pkg::*;

   logic              ihit;
   logic [WORD_W-1:0] instr;
   logic              dhit;
   logic              dRENi;
   logic              dWENi;
   logic              halt_i;
   logic              imemREN;
   logic              dmemREN;
   logic              dmemWEN;
   logic [WORD_W-1:0] instr_q;
   logic              pcEN;
   logic              halt;
   logic              timeout;
   logic [CNT_W-1:0]  retired;

   modport ru (
      input  ihit, instr, dhit, dRENi, dWENi, halt_i,
      output imemREN, dmemREN, dmemWEN, instr_q, pcEN, halt, timeout, retired
   );

   modport mem (
      output ihit, instr, dhit,
      input  imemREN, dmemREN, dmemWEN
   );

   modport cu (
      input  instr_q, pcEN, halt, timeout, retired,
      output dRENi, dWENi, halt_i
   );

endinterface

// File: rtl/wait_counter.sv
// Clearable up-counter with terminal count at MAX_WAIT; clr has priority over inc.
// Holds at MAX_WAIT rather than wrapping so tc stays asserted until cleared.
module wait_counter #(
   parameter int MAX_WAIT = 255
) (
   input  logic clk,
   input  logic clr,
   input  logic inc,
   output logic tc
);
   localparam int W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [W-1:0] cnt;

   assign tc = (cnt == W'(MAX_WAIT));

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (inc && !tc) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/request_unit.sv
// Fetch/decode/data handshake sequencer: 2 cycles per ALU op, 3+ per load/store.
// Stalls in FETCH/DATA until the memory hit; a watchdog halts the unit after MAX_WAIT idle cycles.
module request_unit
   import control_unit_types_pkg::*;
#(
   parameter int MAX_WAIT = 255,
   parameter int CNT_W    = 32
) (
   input  logic        CLK,
   input  logic        RST,
   request_unit_if.ru  bus
);

   ru_state_t         state, state_n;
   logic [WORD_W-1:0] instr_q_r;
   logic [CNT_W-1:0]  retired_r;
   logic              halt_r;
   logic              timeout_r;

   logic imem_ren, dmem_ren, dmem_wen, pc_en, trip;
   logic hit, wd_clr, wd_inc, wd_tc;

   assign hit = ((state == FETCH) && bus.ihit) || ((state == DATA) && bus.dhit);

   always_comb begin
      state_n  = state;
      imem_ren = 1'b0;
      dmem_ren = 1'b0;
      dmem_wen = 1'b0;
      pc_en    = 1'b0;
      trip     = 1'b0;
      case (state)
         FETCH: begin
            imem_ren = 1'b1;
            if (bus.ihit) begin
               state_n = DECODE;
            end else if (wd_tc) begin
               trip    = 1'b1;
               state_n = HALTED;
            end
         end
         DECODE: begin
            if (bus.halt_i) begin
               state_n = HALTED;
            end else if (bus.dRENi || bus.dWENi) begin
               state_n = DATA;
            end else begin
               pc_en   = 1'b1;
               state_n = FETCH;
            end
         end
         DATA: begin
            // A store takes precedence if the decoder raises both requests.
            dmem_wen = bus.dWENi;
            dmem_ren = bus.dRENi && !bus.dWENi;
            if (bus.dhit) begin
               pc_en   = 1'b1;
               state_n = FETCH;
            end else if (wd_tc) begin
               trip    = 1'b1;
               state_n = HALTED;
            end
         end
         HALTED: begin
            state_n = HALTED;
         end
         default: begin
            state_n = FETCH;
         end
      endcase
      // Reset aborts the access in flight and presents the idle FETCH outputs.
      if (RST) begin
         state_n  = FETCH;
         imem_ren = 1'b1;
         dmem_ren = 1'b0;
         dmem_wen = 1'b0;
         pc_en    = 1'b0;
         trip     = 1'b0;
      end
   end

   assign wd_clr = RST || (state_n != state);
   assign wd_inc = is_wait_state(state) && !hit;

   wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_counter (
      .clk (CLK),
      .clr (wd_clr),
      .inc (wd_inc),
      .tc  (wd_tc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= FETCH;
         instr_q_r <= '0;
         retired_r <= '0;
         halt_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state <= state_n;
         if ((state == FETCH) && bus.ihit) begin
            instr_q_r <= bus.instr;
         end
         if (pc_en) begin
            retired_r <= retired_r + CNT_W'(1);
         end
         if (state_n == HALTED) begin
            halt_r <= 1'b1;
         end
         if (trip) begin
            timeout_r <= 1'b1;
         end
      end
   end

   assign bus.imemREN = imem_ren;
   assign bus.dmemREN = dmem_ren;
   assign bus.dmemWEN = dmem_wen;
   assign bus.pcEN    = pc_en;
   assign bus.instr_q = instr_q_r;
   assign bus.retired = retired_r;
   assign bus.halt    = halt_r;
   assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit with MAX_WAIT=4 and CNT_W=4; inputs change and
// outputs are sampled in the low clock phase, away from the rising edge.
module tb_request_unit;

   localparam logic [31:0] I_ADDU = 32'h0022_1821;
   localparam logic [31:0] I_LW   = 32'h8C22_0004;
   localparam logic [31:0] I_SW   = 32'hAC22_0004;
   localparam logic [31:0] I_HALT = 32'hFFFF_FFFF;

   logic CLK = 1'b0;
   logic RST;
   int   checks = 0;
   int   errors = 0;
   logic [3:0] exp_ret;

   request_unit_if #(.CNT_W(4)) bus ();

   request_unit #(
      .MAX_WAIT (4),
      .CNT_W    (4)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.ihit   = 1'b0;
      bus.instr  = '0;
      bus.dhit   = 1'b0;
      bus.dRENi  = 1'b0;
      bus.dWENi  = 1'b0;
      bus.halt_i = 1'b0;
   endtask

   // Two reset cycles; returns in the low phase of FETCH cycle 0 with RST released.
   task automatic reset_dut();
      RST = 1'b1;
      clear_inputs();
      repeat (2) @(negedge CLK);
      #1;
      check("rst_imemREN", 32'(bus.imemREN), 32'd1);
      check("rst_dmemREN", 32'(bus.dmemREN), 32'd0);
      check("rst_dmemWEN", 32'(bus.dmemWEN), 32'd0);
      check("rst_pcEN",    32'(bus.pcEN),    32'd0);
      check("rst_halt",    32'(bus.halt),    32'd0);
      check("rst_timeout", 32'(bus.timeout), 32'd0);
      check("rst_retired", 32'(bus.retired), 32'd0);
      check("rst_instr_q", bus.instr_q,      32'd0);
      RST = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      clear_inputs();
      reset_dut();

      // SW interrupted by reset in the same cycle as its dhit
      bus.ihit = 1'b1; bus.instr = I_SW;
      #1 check("sw_fetch_imemREN", 32'(bus.imemREN), 32'd1);
      @(negedge CLK); bus.ihit = 1'b0; bus.dWENi = 1'b1;
      #1 check("sw_dec_instr_q", bus.instr_q, I_SW);
      check("sw_dec_pcEN", 32'(bus.pcEN), 32'd0);
      @(negedge CLK);
      #1 check("sw_data_dmemWEN", 32'(bus.dmemWEN), 32'd1);
      check("sw_data_dmemREN", 32'(bus.dmemREN), 32'd0);
      @(negedge CLK); bus.dhit = 1'b1; RST = 1'b1;
      #1 check("sw_rst_pcEN", 32'(bus.pcEN), 32'd0);
      @(negedge CLK); RST = 1'b0; bus.dhit = 1'b0; bus.dWENi = 1'b0;
      #1 check("sw_rst_imemREN", 32'(bus.imemREN), 32'd1);
      check("sw_rst_dmemWEN", 32'(bus.dmemWEN), 32'd0);
      check("sw_rst_retired", 32'(bus.retired), 32'd0);
      check("sw_rst_instr_q", bus.instr_q, 32'd0);

      // ADDU: pcEN one cycle after ihit, then back to FETCH
      bus.ihit = 1'b1; bus.instr = I_ADDU;
      #1 check("addu_fetch_pcEN", 32'(bus.pcEN), 32'd0);
      @(negedge CLK); bus.ihit = 1'b0;
      #1 check("addu_dec_pcEN", 32'(bus.pcEN), 32'd1);
      check("addu_dec_imemREN", 32'(bus.imemREN), 32'd0);
      check("addu_dec_instr_q", bus.instr_q, I_ADDU);
      @(negedge CLK);
      #1 check("addu_next_pcEN", 32'(bus.pcEN), 32'd0);
      check("addu_next_imemREN", 32'(bus.imemREN), 32'd1);
      check("addu_retired", 32'(bus.retired), 32'd1);

      // LW with dhit on the third DATA cycle
      bus.ihit = 1'b1; bus.instr = I_LW;
      @(negedge CLK); bus.ihit = 1'b0; bus.dRENi = 1'b1;
      #1 check("lw_dec_pcEN", 32'(bus.pcEN), 32'd0);
      check("lw_dec_dmemREN", 32'(bus.dmemREN), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK); bus.dhit = (i == 2);
         #1 check("lw_data_dmemREN", 32'(bus.dmemREN), 32'd1);
         check("lw_data_dmemWEN", 32'(bus.dmemWEN), 32'd0);
         check("lw_data_pcEN", 32'(bus.pcEN), (i == 2) ? 32'd1 : 32'd0);
      end
      @(negedge CLK); bus.dhit = 1'b0; bus.dRENi = 1'b0;
      #1 check("lw_retired", 32'(bus.retired), 32'd2);
      check("lw_next_imemREN", 32'(bus.imemREN), 32'd1);
      check("lw_next_dmemREN", 32'(bus.dmemREN), 32'd0);

      // HALT: sticky, ignores further hits
      bus.ihit = 1'b1; bus.instr = I_HALT;
      @(negedge CLK); bus.ihit = 1'b0; bus.halt_i = 1'b1;
      #1 check("halt_dec_pcEN", 32'(bus.pcEN), 32'd0);
      check("halt_dec_halt", 32'(bus.halt), 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK); bus.ihit = i[0]; bus.dhit = i[0]; bus.instr = 32'(i);
         #1 check("halted_halt", 32'(bus.halt), 32'd1);
         check("halted_imemREN", 32'(bus.imemREN), 32'd0);
         check("halted_dmem", 32'({bus.dmemREN, bus.dmemWEN}), 32'd0);
         check("halted_pcEN", 32'(bus.pcEN), 32'd0);
         check("halted_retired", 32'(bus.retired), 32'd2);
         check("halted_instr_q", bus.instr_q, I_HALT);
         check("halted_timeout", 32'(bus.timeout), 32'd0);
      end

      // Watchdog trip: no ihit for 5 FETCH cycles
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge CLK);
         #1 check("wd_wait_timeout", 32'(bus.timeout), 32'd0);
         check("wd_wait_imemREN", 32'(bus.imemREN), 32'd1);
      end
      @(negedge CLK);
      #1 check("wd_trip_timeout", 32'(bus.timeout), 32'd1);
      check("wd_trip_halt", 32'(bus.halt), 32'd1);
      check("wd_trip_imemREN", 32'(bus.imemREN), 32'd0);
      @(negedge CLK); bus.ihit = 1'b1;
      #1 check("wd_stay_imemREN", 32'(bus.imemREN), 32'd0);

      // Watchdog boundary: ihit on the 5th FETCH cycle wins
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge CLK);
         #1 check("wdb_wait_imemREN", 32'(bus.imemREN), 32'd1);
      end
      @(negedge CLK); bus.ihit = 1'b1; bus.instr = I_ADDU;
      #1 check("wdb_hit_timeout", 32'(bus.timeout), 32'd0);
      @(negedge CLK); bus.ihit = 1'b0;
      #1 check("wdb_dec_timeout", 32'(bus.timeout), 32'd0);
      check("wdb_dec_halt", 32'(bus.halt), 32'd0);
      check("wdb_dec_pcEN", 32'(bus.pcEN), 32'd1);
      @(negedge CLK);
      #1 check("wdb_retired", 32'(bus.retired), 32'd1);

      // Retired counter wrap over 17 back-to-back ADDUs
      reset_dut();
      exp_ret = 4'd0;
      for (int n = 1; n <= 17; n++) begin
         bus.ihit = 1'b1; bus.instr = I_ADDU;
         @(negedge CLK); bus.ihit = 1'b0;
         #1 check("wrap_pcEN", 32'(bus.pcEN), 32'd1);
         exp_ret = exp_ret + 4'd1;
         @(negedge CLK);
         #1 check("wrap_retired", 32'(bus.retired), 32'(exp_ret));
      end
      check("wrap_final", 32'(bus.retired), 32'd1);

      // Both requests set: store wins
      bus.ihit = 1'b1; bus.instr = I_LW;
      @(negedge CLK); bus.ihit = 1'b0; bus.dRENi = 1'b1; bus.dWENi = 1'b1;
      @(negedge CLK);
      #1 check("both_dmemWEN", 32'(bus.dmemWEN), 32'd1);
      check("both_dmemREN", 32'(bus.dmemREN), 32'd0);
      check("both_imemREN", 32'(bus.imemREN), 32'd0);
      @(negedge CLK); bus.dhit = 1'b1;
      #1 check("both_hit_pcEN", 32'(bus.pcEN), 32'd1);
      check("both_hit_dmemWEN", 32'(bus.dmemWEN), 32'd1);
      check("both_hit_dmemREN", 32'(bus.dmemREN), 32'd0);
      @(negedge CLK); bus.dhit = 1'b0; bus.dRENi = 1'b0; bus.dWENi = 1'b0;
      #1 check("both_retired", 32'(bus.retired), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
